fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle fetch/control sequencer directly upstream of the program counter.
- Fetches the instruction at the current PC and latches it for the execute stage.
- Resolves Bcond/Jcond instructions against the condition flags.
- Issues the one-cycle PC update command (en, newAdr, imm) that the program counter consumes.

Parameters:
- DATA_WIDTH, 16, instruction/data/address width.
- REG_SEL_WIDTH, 4, register-file select width for jump target.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pc  input  16  current PC value from the program counter.
- mem_addr  output  16  instruction memory address (synchronous read, 1-cycle latency).
- mem_rdata  input  16  instruction memory read data.
- flags  input  5  {C, L, F, Z, N} from the ALU flag register, bit 4 = C.
- rtarget_sel  output  4  register-file read select for jump target.
- rtarget_data  input  16  register-file read data (combinational).
- instr  output  16  latched instruction register.
- instr_valid  output  1  instr is valid for execute stage.
- exec_done  input  1  execute stage finished current instruction.
- pc_en  output  2  PC command: 00 hold, 01 increment, 10 jump, 11 branch.
- new_adr  output  16  jump target, valid while pc_en = 10.
- imm  output  16  sign-extended branch displacement, valid while pc_en = 11.

Behaviour:
- All outputs are registered.
- Reset values: mem_addr=0, rtarget_sel=0, instr=0, instr_valid=0, pc_en=00, new_adr=0, imm=0. State = FETCH.
- Reset mid-operation: abort the current instruction and return to FETCH next cycle. pc_en is 00 during reset, so the PC is never commanded during reset.
- States and transitions:
  - FETCH: mem_addr <= pc; go to WAIT.
  - WAIT: go to LOAD (memory latency cycle).
  - LOAD: instr <= mem_rdata; rtarget_sel <= mem_rdata[3:0]; go to DECODE.
  - DECODE: classify instr; compute the command (see below); instr_valid <= 1; go to EXEC.
  - EXEC: hold instr_valid=1 until exec_done=1. On that edge: instr_valid <= 0; pc_en <= the command computed in DECODE; go to UPDATE.
  - UPDATE: pc_en <= 00; go to FETCH.
- pc_en is nonzero for exactly one cycle per instruction. The PC changes on the edge that ends that cycle, so the next FETCH samples the updated pc.
- exec_done is ignored outside EXEC. If exec_done is already high on entry to EXEC, leave EXEC after a single cycle.
- Latency: pc change to instr_valid is 4 cycles minimum (FETCH, WAIT, LOAD, DECODE). Minimum instruction period is 6 cycles.
- Decode rules:
  - Bcond: instr[15:12]=1100; cond=instr[11:8]; disp=instr[7:0]; imm <= sign-extend(disp) to 16 bits. Taken gives 11, not taken gives 01.
  - Jcond: instr[15:12]=0100 and instr[7:4]=1100; cond=instr[11:8]; new_adr <= rtarget_data, sampled in DECODE. Taken gives 10, not taken gives 01.
  - All other encodings give 01.
- Condition codes:
  - EQ 0000: Z=1.
  - NE 0001: Z=0.
  - CS 0010: C=1.
  - CC 0011: C=0.
  - HI 0100: L=1.
  - LS 0101: L=0.
  - GT 0110: N=1.
  - LE 0111: N=0.
  - FS 1000: F=1.
  - FC 1001: F=0.
  - LO 1010: L=0 and Z=0.
  - HS 1011: L=1 or Z=1.
  - LT 1100: N=0 and Z=0.
  - GE 1101: N=1 or Z=1.
  - UC 1110: always.
  - 1111: never (not taken).
- Flags are sampled in DECODE. Flag changes during EXEC do not alter an already-resolved decision.
- Arithmetic: imm is a two's-complement 16-bit value. Wrap-around of pc+imm is handled by the PC modulo 2^16; no saturation here.
- A taken branch with disp=0 is legal: emit pc_en=11, imm=0, and the PC holds.
- new_adr and imm keep their last values when not in use.

Test Plan:
- Reset then non-control instr 0x0000 at pc=0x0000, exec_done pulsed in EXEC -> mem_addr=0x0000; instr=0x0000 with instr_valid=1 four cycles after reset release; one-cycle pc_en=01.
- Bcond EQ, instr=0xC0FC, flags Z=1 -> imm=0xFFFC, one-cycle pc_en=11. Same instr with Z=0 -> pc_en=01, imm still 0xFFFC.
- Jcond UC, instr=0x4EC5, rtarget_data=0x1234 -> rtarget_sel=5, new_adr=0x1234, pc_en=10. Cond 1111 (0x4FC5) -> pc_en=01.
- LO/HS boundary: instr=0xCA10 with L=0,Z=0 -> 11; with L=0,Z=1 -> 01. instr=0xCB10 with L=0,Z=1 -> 11.
- exec_done held low 10 cycles -> instr_valid stays 1 and pc_en stays 00 throughout. exec_done pulsed while in WAIT -> ignored, no pc_en.
- Reset asserted in EXEC with instr_valid=1 -> next cycle instr_valid=0, pc_en=00, state FETCH. No pc_en pulse for the aborted instruction.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Multi-cycle fetch/control sequencer that sits just upstream of the program
//   counter. It fetches the instruction at pc, latches it for the execute stage,
//   resolves Bcond/Jcond against the ALU flags, and issues the one-cycle PC
//   update command once execute reports done.
//
// Ports
//   clk, reset     : clock; synchronous active-high reset
//   pc             : current PC from the program counter
//   mem_addr       : instruction memory address (memory has 1-cycle read latency)
//   mem_rdata      : instruction memory read data
//   flags          : {C, L, F, Z, N} from the ALU flag register
//   rtarget_sel    : register-file select for the jump target (instr[3:0])
//   rtarget_data   : register-file read data (combinational)
//   instr          : latched instruction register
//   instr_valid    : instr is valid for the execute stage
//   exec_done      : execute stage finished the current instruction
//   pc_en          : PC command 00 hold, 01 inc, 10 jump, 11 branch
//   new_adr        : jump target (meaningful while pc_en = 10)
//   imm            : sign-extended branch displacement (meaningful while pc_en = 11)
module fetch_sequencer #(
    parameter int DATA_WIDTH    = 16,
    parameter int REG_SEL_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    pc,
    output logic [DATA_WIDTH-1:0]    mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic [4:0]               flags,
    output logic [REG_SEL_WIDTH-1:0] rtarget_sel,
    input  logic [DATA_WIDTH-1:0]    rtarget_data,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic                     instr_valid,
    input  logic                     exec_done,
    output logic [1:0]               pc_en,
    output logic [DATA_WIDTH-1:0]    new_adr,
    output logic [DATA_WIDTH-1:0]    imm
);

    typedef enum logic [2:0] {
        S_FETCH, S_WAIT, S_LOAD, S_DECODE, S_EXEC, S_UPDATE
    } state_t;

    localparam logic [1:0] CMD_INC    = 2'b01;
    localparam logic [1:0] CMD_JUMP   = 2'b10;
    localparam logic [1:0] CMD_BRANCH = 2'b11;

    state_t     state;
    logic [1:0] cmd;    // command resolved in DECODE, issued when EXEC ends

    // flags = {C, L, F, Z, N}
    function automatic logic cond_true(input logic [3:0] cond, input logic [4:0] f);
        logic c, l, fl, z, n;
        {c, l, fl, z, n} = f;
        case (cond)
            4'b0000: cond_true = z;
            4'b0001: cond_true = !z;
            4'b0010: cond_true = c;
            4'b0011: cond_true = !c;
            4'b0100: cond_true = l;
            4'b0101: cond_true = !l;
            4'b0110: cond_true = n;
            4'b0111: cond_true = !n;
            4'b1000: cond_true = fl;
            4'b1001: cond_true = !fl;
            4'b1010: cond_true = !l && !z;
            4'b1011: cond_true = l || z;
            4'b1100: cond_true = !n && !z;
            4'b1101: cond_true = n || z;
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    endfunction

    logic is_bcond, is_jcond, taken;
    assign is_bcond = (instr[15:12] == 4'b1100);
    assign is_jcond = (instr[15:12] == 4'b0100) && (instr[7:4] == 4'b1100);
    assign taken    = cond_true(instr[11:8], flags);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            mem_addr    <= '0;
            rtarget_sel <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_en       <= 2'b00;
            new_adr     <= '0;
            imm         <= '0;
            cmd         <= 2'b00;
        end else begin
            case (state)
                S_FETCH: begin
                    mem_addr <= pc;
                    state    <= S_WAIT;
                end
                S_WAIT: state <= S_LOAD;
                S_LOAD: begin
                    instr       <= mem_rdata;
                    rtarget_sel <= mem_rdata[REG_SEL_WIDTH-1:0];
                    state       <= S_DECODE;
                end
                S_DECODE: begin
                    // imm/new_adr load on any Bcond/Jcond so they track the
                    // last decoded control instruction, taken or not.
                    cmd <= CMD_INC;
                    if (is_bcond) begin
                        imm <= {{(DATA_WIDTH-8){instr[7]}}, instr[7:0]};
                        if (taken) cmd <= CMD_BRANCH;
                    end else if (is_jcond) begin
                        new_adr <= rtarget_data;
                        if (taken) cmd <= CMD_JUMP;
                    end
                    instr_valid <= 1'b1;
                    state       <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_done) begin
                        instr_valid <= 1'b0;
                        pc_en       <= cmd;
                        state       <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    // PC moves on this edge; next FETCH sees the new value.
                    pc_en <= 2'b00;
                    state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [4:0]  flags;
    logic [3:0]  rtarget_sel;
    logic [15:0] rtarget_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic [1:0]  pc_en;
    logic [15:0] new_adr;
    logic [15:0] imm;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .pc(pc), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .flags(flags), .rtarget_sel(rtarget_sel), .rtarget_data(rtarget_data),
        .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
        .pc_en(pc_en), .new_adr(new_adr), .imm(imm)
    );

    // Environment: program counter, synchronous instruction memory, register file.
    logic [15:0] mem [0:255];
    always @(posedge clk) mem_rdata <= mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (reset) pc <= 16'h0000;
        else case (pc_en)
            2'b01: pc <= pc + 16'd1;
            2'b10: pc <= new_adr;
            2'b11: pc <= pc + imm;
            default: ;
        endcase
    end
    assign rtarget_data = (rtarget_sel == 4'd5) ? 16'h1234 : 16'hDEAD;

    typedef struct packed {
        logic [15:0] instr;
        logic [4:0]  flags;
        logic [1:0]  cmd;
        logic [15:0] imm;
        logic [15:0] nadr;
        logic [3:0]  hold;
        logic        early;
    } vec_t;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [15:0] instr;
        logic [15:0] imm;
        logic [15:0] nadr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every PC command the DUT presents must match the next expectation.
    always @(negedge clk) begin
        if (!reset && pc_en != 2'b00) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pc_en: got %b expected none", pc_en);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pc_en",   {30'd0, pc_en}, {30'd0, e.cmd});
                chk("cmd_instr", {16'd0, instr}, {16'd0, e.instr});
                chk("imm",     {16'd0, imm},     {16'd0, e.imm});
                chk("new_adr", {16'd0, new_adr}, {16'd0, e.nadr});
            end
        end
    end

    // Starts in the FETCH cycle (just after a posedge), returns in the next FETCH cycle.
    task automatic run(input vec_t v);
        int n;
        exp_t e;
        mem[pc[7:0]] = v.instr;
        flags = v.flags;
        e.cmd = v.cmd; e.instr = v.instr; e.imm = v.imm; e.nadr = v.nadr;
        sb.push_back(e);
        n = 0;
        if (v.early) begin
            @(posedge clk); #1; n++;        // now in WAIT
            exec_done = 1'b1;
            @(posedge clk); #1; n++;
            exec_done = 1'b0;
        end
        while (!instr_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("valid_latency", n, 4);
        chk("instr", {16'd0, instr}, {16'd0, v.instr});
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, pc});
        chk("rtarget_sel", {28'd0, rtarget_sel}, {28'd0, v.instr[3:0]});
        flags = ~v.flags;                   // must not affect the resolved decision
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, instr_valid}, 1);
            chk("hold_pc_en", {30'd0, pc_en}, 0);
        end
        exec_done = 1'b1;
        @(posedge clk); #1;
        exec_done = 1'b0;
        chk("valid_drop", {31'd0, instr_valid}, 0);
        @(posedge clk); #1;
        chk("pc_en_one_cycle", {30'd0, pc_en}, 0);
    endtask

    vec_t vecs[14];

    initial begin
        //          instr     flags     cmd    imm       nadr      hold  early
        vecs[0]  = '{16'h0000, 5'b00000, 2'b01, 16'h0000, 16'h0000, 4'd0, 1'b0};
        vecs[1]  = '{16'hC0FC, 5'b00010, 2'b11, 16'hFFFC, 16'h0000, 4'd0, 1'b0};
        vecs[2]  = '{16'hC0FC, 5'b00000, 2'b01, 16'hFFFC, 16'h0000, 4'd0, 1'b0};
        vecs[3]  = '{16'h4EC5, 5'b00000, 2'b10, 16'hFFFC, 16'h1234, 4'd0, 1'b0};
        vecs[4]  = '{16'h4FC5, 5'b11111, 2'b01, 16'hFFFC, 16'h1234, 4'd0, 1'b0};
        vecs[5]  = '{16'hCA10, 5'b00000, 2'b11, 16'h0010, 16'h1234, 4'd0, 1'b0};
        vecs[6]  = '{16'hCA10, 5'b00010, 2'b01, 16'h0010, 16'h1234, 4'd0, 1'b0};
        vecs[7]  = '{16'hCB10, 5'b00010, 2'b11, 16'h0010, 16'h1234, 4'd0, 1'b0};
        vecs[8]  = '{16'hC000, 5'b00010, 2'b11, 16'h0000, 16'h1234, 4'd0, 1'b0};
        vecs[9]  = '{16'hCE80, 5'b00000, 2'b11, 16'hFF80, 16'h1234, 4'd0, 1'b0};
        vecs[10] = '{16'hC405, 5'b01000, 2'b11, 16'h0005, 16'h1234, 4'd10, 1'b0};
        vecs[11] = '{16'h1234, 5'b00000, 2'b01, 16'h0005, 16'h1234, 4'd0, 1'b1};
        vecs[12] = '{16'h4E35, 5'b00000, 2'b01, 16'h0005, 16'h1234, 4'd0, 1'b0};
        // after the reset abort: imm/new_adr were cleared by reset
        vecs[13] = '{16'h0000, 5'b00000, 2'b01, 16'h0000, 16'h0000, 4'd0, 1'b0};

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset = 1'b1; exec_done = 1'b0; flags = 5'b00000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_addr", {16'd0, mem_addr}, 0);
        chk("rst_rtarget_sel", {28'd0, rtarget_sel}, 0);
        chk("rst_instr", {16'd0, instr}, 0);
        chk("rst_valid", {31'd0, instr_valid}, 0);
        chk("rst_pc_en", {30'd0, pc_en}, 0);
        chk("rst_new_adr", {16'd0, new_adr}, 0);
        chk("rst_imm", {16'd0, imm}, 0);
        reset = 1'b0;
        @(posedge clk); #1;                 // FETCH edge consumed; now in WAIT
        // realign: run() expects to start in FETCH, so restart cleanly
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;                       // now in FETCH cycle

        for (int i = 0; i < 13; i++) run(vecs[i]);

        // Reset abort in EXEC: no command may come out for this instruction.
        begin
            int n;
            mem[pc[7:0]] = 16'hCE01;
            flags = 5'b00000;
            n = 0;
            while (!instr_valid && n < 20) begin
                @(posedge clk); #1; n++;
            end
            chk("abort_valid_seen", {31'd0, instr_valid}, 1);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            chk("abort_valid", {31'd0, instr_valid}, 0);
            chk("abort_pc_en", {30'd0, pc_en}, 0);
            chk("abort_instr", {16'd0, instr}, 0);
            chk("abort_pc", {16'd0, pc}, 0);
        end
        run(vecs[13]);
        chk("final_pc", {16'd0, pc}, 1);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
